// File: rtl/voice_allocator.sv
// Voice allocator: shares a pool of note-player voices between incoming note
// requests. Each voice holds a note code and a beat countdown. A new note
// reuses a voice already playing the same note, else takes a free voice, else
// steals the active voice closest to finishing.
module voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int IDX_W      = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    play,
  input  logic                    beat,
  input  logic                    load_new_note,
  input  logic [5:0]              note_to_load,
  input  logic [5:0]              duration_to_load,
  output logic [6*NUM_VOICES-1:0] voice_note,
  output logic [NUM_VOICES-1:0]   voice_active,
  output logic [NUM_VOICES-1:0]   voice_load,
  output logic                    alloc_valid,
  output logic [IDX_W-1:0]        alloc_voice,
  output logic                    alloc_steal
);

  logic [5:0] note_q [NUM_VOICES];
  logic [5:0] rem_q  [NUM_VOICES];

  logic             req_ok;
  logic             retrig_hit;
  logic [IDX_W-1:0] retrig_idx;
  logic             free_hit;
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] steal_idx;
  logic [5:0]       steal_rem;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_steal;

  // Choose a voice for the incoming request from the pre-edge voice state.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    req_ok     = load_new_note && (note_to_load != 6'd0) && (duration_to_load != 6'd0);
    retrig_hit = 1'b0;
    retrig_idx = '0;
    free_hit   = 1'b0;
    free_idx   = '0;
    steal_idx  = '0;
    steal_rem  = '1;
    sel_idx    = '0;
    sel_steal  = 1'b0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (!retrig_hit && (rem_q[i] != 6'd0) && (note_q[i] == note_to_load)) begin
        retrig_hit = 1'b1;
        retrig_idx = IDX_W'(i);
      end
      if (!free_hit && (rem_q[i] == 6'd0)) begin
        free_hit = 1'b1;
        free_idx = IDX_W'(i);
      end
      // Strict compare keeps the lowest index on ties.
      if (rem_q[i] < steal_rem) begin
        steal_rem = rem_q[i];
        steal_idx = IDX_W'(i);
      end
    end
    if (retrig_hit) begin
      sel_idx = retrig_idx;
    end else if (free_hit) begin
      sel_idx = free_idx;
    end else begin
      sel_idx   = steal_idx;
      sel_steal = 1'b1;
    end
  end

  // Voice state update (load or beat countdown) and registered allocation strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the voice arrays are a handful of flops whose contents drive outputs, so they are reset like any register.
      for (int i = 0; i < NUM_VOICES; i++) begin
        note_q[i] <= '0;
        rem_q[i]  <= '0;
      end
      voice_load  <= '0;
      alloc_valid <= 1'b0;
      alloc_voice <= '0;
      alloc_steal <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every voice sees the same pre-edge state.
      voice_load  <= '0;
      alloc_valid <= req_ok;
      alloc_voice <= req_ok ? sel_idx : '0;
      alloc_steal <= req_ok && sel_steal;
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (req_ok && (sel_idx == IDX_W'(i))) begin
          note_q[i]     <= note_to_load;
          rem_q[i]      <= duration_to_load;
          voice_load[i] <= 1'b1;
        end else if (play && beat && (rem_q[i] != 6'd0)) begin
          rem_q[i] <= rem_q[i] - 6'd1;
        end
      end
    end
  end

  // Flatten per-voice state onto the output buses.
  always_comb begin
    voice_note   = '0;
    voice_active = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      voice_note[6*i +: 6] = note_q[i];
      voice_active[i]      = (rem_q[i] != 6'd0);
    end
  end

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Scheduler that shares a fixed pool of note-player voices between incoming note load requests from the song reader.
- Picks a voice for each new note and tracks each voice's remaining duration in beats. Frees voices on expiry and steals a voice when the pool is full.
- Sits between the song reader and the note players inside the note distribution path.
- Drives per-voice note codes and one-cycle load strobes.

Parameters:
- NUM_VOICES, 4, number of note-player voices managed (2..8).
- IDX_W, 2, width of a voice index; must satisfy 2^IDX_W >= NUM_VOICES.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- play  in  1  1 = duration counting enabled; 0 = paused, durations frozen.
- beat  in  1  one-cycle beat pulse from the beat generator.
- load_new_note  in  1  one-cycle request to start a note.
- note_to_load  in  6  note code; 0 = rest.
- duration_to_load  in  6  duration in beats.
- voice_note  out  6*NUM_VOICES  note code per voice; voice i occupies bits [6i+5:6i].
- voice_active  out  NUM_VOICES  1 = voice i is sounding.
- voice_load  out  NUM_VOICES  one-cycle strobe telling note player i to restart on voice_note[i].
- alloc_valid  out  1  one-cycle pulse: the request was accepted.
- alloc_voice  out  IDX_W  voice chosen; valid while alloc_valid=1.
- alloc_steal  out  1  one-cycle pulse with alloc_valid when an active voice was preempted.

Behaviour:
- Reset (reset=0, asynchronous):
  - All voice_note, remaining counters, voice_active, voice_load, alloc_valid, alloc_voice and alloc_steal go to 0.
  - Takes effect mid-operation; pending strobes are dropped.
- Per-voice state: note (6b), remaining (6b), active (1b). active equals (remaining != 0).
- Latency: a request sampled at edge N updates note/remaining/active at edge N. voice_load[i], alloc_valid, alloc_voice and alloc_steal are high for exactly the cycle after edge N.
- Request filtering: a request with note_to_load=0 or duration_to_load=0 is dropped. No strobes; state unchanged.
- Requests are accepted regardless of play.
- Allocation priority, evaluated on the pre-edge state:
  - 1 Retrigger: if an active voice already holds note_to_load, reuse the lowest such index. Reload remaining. alloc_steal=0.
  - 2 Free: otherwise pick the lowest-index inactive voice. alloc_steal=0.
  - 3 Steal: otherwise pick the active voice with the smallest remaining, ties to the lowest index. alloc_steal=1.
- Chosen voice: note<=note_to_load, remaining<=duration_to_load, voice_load[idx] pulses.
- Beat counting:
  - On an edge with beat=1 and play=1, every active voice not being loaded this edge decrements remaining by 1.
  - A voice reaching 0 goes inactive at that edge. Its note holds its last value; no strobe.
- beat with play=0: ignored, no decrement.
- Simultaneous beat and load:
  - The loaded voice takes the full duration_to_load, with no decrement this edge.
  - A voice expiring on this same edge (remaining=1) still counts as active for allocation and retrigger.
  - All other voices decrement normally.
- Back-to-back requests on consecutive cycles are each serviced. The second sees the state written by the first.
- Counters never underflow; remaining=0 is never decremented.
- At most one voice_load bit is high in any cycle.

Test Plan:
- Reset, then load note 40 dur 3 → next cycle voice_load=0001, alloc_voice=0, alloc_steal=0. voice_note[0]=40, voice_active=0001.
- From that state, play=1 with 3 beats → voice_active[0] drops to 0 on the 3rd beat edge; voice_note[0] stays 40; no strobe.
- Load notes 40, 44, 47, 50 (dur 5, 4, 3, 6), then load 52 dur 2 → 52 steals voice 2 (remaining 3 is smallest). alloc_steal=1, voice_load=0100.
- With voice 0 active on 40 (remaining 2), load 40 dur 6 → retrigger voice 0, remaining=6, voice_load=0001, alloc_steal=0; no other voice touched.
- Load note 0 dur 4, then note 33 dur 0 → no alloc_valid, no voice_load, state unchanged. play=0 with beats → remaining values frozen.
- Same cycle: beat with play=1 while voice 1 has remaining=1, plus load of note 45 with voices 0/2/3 active → voice 1 is not free, so 45 steals voice 1. Voice 1 ends active with remaining = new duration.
- Assert reset mid-sequence with 3 voices active → all outputs are 0 immediately. After release, the first load goes to voice 0.
